// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and frame sizing.
// Used by both the transmit framer and the receiver.
package uart_pkg;

  localparam logic [2:0] IDLE_ENC   = 3'd0;
  localparam logic [2:0] START_ENC  = 3'd1;
  localparam logic [2:0] DATA_ENC   = 3'd2;
  localparam logic [2:0] PARITY_ENC = 3'd3;
  localparam logic [2:0] STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = IDLE_ENC,
    START  = START_ENC,
    DATA   = DATA_ENC,
    PARITY = PARITY_ENC,
    STOP   = STOP_ENC
  } uart_state_e;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  function automatic int unsigned frame_cycles(input int unsigned word_length,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits,
                                               input int unsigned clks_per_bit);
    return (1 + word_length + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end is high on the last clock of each bit period.
// restart realigns the count to a new frame start.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST_CNT);

  always_ff @(posedge Clk) begin
    if (Reset || restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity and stop bits,
// with a one-word holding buffer for gap-free back-to-back frames.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [WORD_LENGTH-1:0] Parallel_In,
  input  logic                   Transmit,
  output logic                   Serial_Out,
  output logic                   Ready,
  output logic                   Busy,
  output logic                   Tx_Done
);

  localparam int IW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_LENGTH - 1);

  function automatic logic calc_parity(input logic [WORD_LENGTH-1:0] word);
    return (^word) ^ (PARITY_ODD != 0);
  endfunction

  uart_state_e            state;
  logic [WORD_LENGTH-1:0] shifter;
  logic [WORD_LENGTH-1:0] holding;
  logic                   buf_full;
  logic                   par_bit;
  logic [IW-1:0]          bit_idx;
  logic                   stop_idx;
  logic                   so_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   done_q;

  logic bit_end;
  logic last_stop;
  logic final_stop;
  logic idle_accept;
  logic reload;
  logic buf_accept;

  assign last_stop   = (STOP_BITS < 2) || stop_idx;
  assign final_stop  = (state == STOP) && bit_end && last_stop;
  assign idle_accept = (state == IDLE) && Transmit && ready_q;
  assign reload      = final_stop && (buf_full || Transmit);
  // The final-stop edge hands a live Transmit straight to the shifter, so it
  // must not also be captured into the holding buffer.
  assign buf_accept  = (state != IDLE) && Transmit && ready_q && !final_stop;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .restart(idle_accept || reload),
    .bit_end(bit_end)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      shifter  <= '0;
      holding  <= '0;
      buf_full <= 1'b0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      so_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (buf_accept) begin
        holding  <= Parallel_In;
        buf_full <= 1'b1;
        ready_q  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (idle_accept) begin
            shifter <= Parallel_In;
            par_bit <= calc_parity(Parallel_In);
            state   <= START;
            so_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            so_q    <= shifter[0];
            shifter <= shifter >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                so_q  <= par_bit;
              end else begin
                state <= STOP;
                so_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              so_q    <= shifter[0];
              shifter <= shifter >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            so_q     <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else begin
              done_q <= 1'b1;
              if (buf_full) begin
                shifter  <= holding;
                par_bit  <= calc_parity(holding);
                buf_full <= 1'b0;
                ready_q  <= 1'b1;
                state    <= START;
                so_q     <= 1'b0;
              end else if (Transmit) begin
                shifter <= Parallel_In;
                par_bit <= calc_parity(Parallel_In);
                state   <= START;
                so_q    <= 1'b0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Serial_Out = so_q;
  assign Busy       = busy_q;
  assign Ready      = ready_q;
  assign Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer across three parameter sets.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: defaults; u1: odd parity, 4 clks/bit; u2: no parity, 2 stop bits
  logic       rst0, tx0, so0, rdy0, busy0, done0;
  logic [7:0] din0;
  logic       rst1, tx1, so1, rdy1, busy1, done1;
  logic [7:0] din1;
  logic       rst2, tx2, so2, rdy2, busy2, done2;
  logic [7:0] din2;

  uart_tx_framer u0 (
    .Clk(clk), .Reset(rst0), .Parallel_In(din0), .Transmit(tx0),
    .Serial_Out(so0), .Ready(rdy0), .Busy(busy0), .Tx_Done(done0)
  );

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u1 (
    .Clk(clk), .Reset(rst1), .Parallel_In(din1), .Transmit(tx1),
    .Serial_Out(so1), .Ready(rdy1), .Busy(busy1), .Tx_Done(done1)
  );

  uart_tx_framer #(.PARITY_EN(0), .STOP_BITS(2)) u2 (
    .Clk(clk), .Reset(rst2), .Parallel_In(din2), .Transmit(tx2),
    .Serial_Out(so2), .Ready(rdy2), .Busy(busy2), .Tx_Done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    tx0 = 1'b0; tx1 = 1'b0; tx2 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    tick();
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    checks++;
    if (so0 !== 1'b1) begin errors++; $display("FAIL reset_so got=%b exp=1", so0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++;
    if ({so1, busy1, rdy1, so2, busy2, rdy2} !== 6'b101101) begin
      errors++;
      $display("FAIL reset_others got=%b exp=101101", {so1, busy1, rdy1, so2, busy2, rdy2});
    end
    tick();
  endtask

  task automatic test_single_frame();
    bit exp_line [0:10] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    din0 = 8'b0000_1001;
    tx0 = 1'b1;
    tick();
    tx0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (so0 !== exp_line[i] || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d got so=%b busy=%b done=%b exp so=%b busy=1 done=0",
                 i, so0, busy0, done0, exp_line[i]);
      end
      tick();
    end
    checks++;
    if (so0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL single_end got so=%b busy=%b done=%b exp so=1 busy=0 done=1", so0, busy0, done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || so0 !== 1'b1) begin
      errors++;
      $display("FAIL single_done_once got done=%b so=%b exp done=0 so=1", done0, so0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // A5 then 3C, even parity; a third word 77 offered while the buffer is full
    bit exp_line [0:23] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1,
                            0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1,
                            1, 1};
    bit got_line [0:23];
    bit got_done [0:23];
    bit got_busy [0:23];
    din0 = 8'hA5;
    tx0 = 1'b1;
    tick();
    got_line[0] = so0; got_done[0] = done0; got_busy[0] = busy0;
    tx0 = 1'b0;
    tick();
    got_line[1] = so0; got_done[1] = done0; got_busy[1] = busy0;
    din0 = 8'h3C;
    tx0 = 1'b1;
    tick();
    got_line[2] = so0; got_done[2] = done0; got_busy[2] = busy0;
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%b exp=0", rdy0); end
    din0 = 8'h77;
    tick();
    got_line[3] = so0; got_done[3] = done0; got_busy[3] = busy0;
    tx0 = 1'b0;
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL overflow_ready got=%b exp=0", rdy0); end
    for (int i = 4; i < 24; i++) begin
      tick();
      got_line[i] = so0; got_done[i] = done0; got_busy[i] = busy0;
      if (i == 11) begin
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b exp=1", rdy0); end
      end
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (got_line[i] !== exp_line[i]) begin
        errors++;
        $display("FAIL b2b_line_cycle%0d got=%b exp=%b", i, got_line[i], exp_line[i]);
      end
      checks++;
      if (got_done[i] !== ((i == 11) || (i == 22))) begin
        errors++;
        $display("FAIL b2b_done_cycle%0d got=%b exp=%b", i, got_done[i], (i == 11) || (i == 22));
      end
      checks++;
      if (got_busy[i] !== (i < 22)) begin
        errors++;
        $display("FAIL b2b_busy_cycle%0d got=%b exp=%b", i, got_busy[i], i < 22);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bit exp_line [0:10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    int done_seen = 0;
    din0 = 8'h55;
    tx0 = 1'b1;
    tick();
    tx0 = 1'b0;
    tick();
    tick();
    tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    checks++;
    if (so0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got so=%b busy=%b ready=%b done=%b exp 1 0 1 0",
               so0, busy0, rdy0, done0);
    end
    for (int i = 0; i < 12; i++) begin
      if (done0 === 1'b1 || so0 !== 1'b1) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midrst_quiet got=%0d bad cycles exp=0", done_seen);
    end
    tx0 = 1'b1;
    tick();
    tx0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (so0 !== exp_line[i] || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL midrst_frame_bit%0d got so=%b busy=%b exp so=%b busy=1",
                 i, so0, busy0, exp_line[i]);
      end
      tick();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_frame_end got done=%b busy=%b exp done=1 busy=0", done0, busy0);
    end
    tick();
  endtask

  task automatic test_odd_parity_slow();
    int busy_cycles = 0;
    bit line_ok = 1'b1;
    int first_bad = -1;
    din1 = 8'hFF;
    tx1 = 1'b1;
    tick();
    tx1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy1 === 1'b1) busy_cycles++;
      // start bit for 4 cycles, then data, odd parity (1) and stop all high
      if (i < 44 && so1 !== (i >= 4) && line_ok) begin
        line_ok = 1'b0;
        first_bad = i;
      end
      if (i == 40) begin
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL odd_early_done got=%b exp=0", done1); end
      end
      if (i == 44) begin
        checks++;
        if (done1 !== 1'b1 || so1 !== 1'b1) begin
          errors++;
          $display("FAIL odd_done got done=%b so=%b exp done=1 so=1", done1, so1);
        end
      end
      tick();
    end
    checks++;
    if (!line_ok) begin
      errors++;
      $display("FAIL odd_line first bad cycle=%0d exp none", first_bad);
    end
    checks++;
    if (busy_cycles != 44) begin
      errors++;
      $display("FAIL odd_frame_len got=%0d exp=44", busy_cycles);
    end
  endtask

  task automatic test_two_stop();
    bit exp_line [0:23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                            0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                            1, 1};
    bit got_line [0:23];
    bit got_done [0:23];
    din2 = 8'h00;
    tx2 = 1'b1;
    tick();
    tx2 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      got_line[i] = so2;
      got_done[i] = done2;
      if (i == 10) begin
        din2 = 8'hFF;
        tx2 = 1'b1;
      end
      if (i == 11) begin
        tx2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("FAIL stop2_busy_gap got=%b exp=1", busy2); end
      end
      tick();
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (got_line[i] !== exp_line[i]) begin
        errors++;
        $display("FAIL stop2_line_cycle%0d got=%b exp=%b", i, got_line[i], exp_line[i]);
      end
      checks++;
      if (got_done[i] !== ((i == 11) || (i == 22))) begin
        errors++;
        $display("FAIL stop2_done_cycle%0d got=%b exp=%b", i, got_done[i], (i == 11) || (i == 22));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_odd_parity_slow();
    test_two_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
